spi_master_tx: RTL and testbench

- SPI master that serialises 32-bit register-write frames to the coefficient SPI slave (w_cos/w_sin registers) from the system clock.
- Frame format, MSB first:
  - bit 31: R/W (1 = write)
  - bits 30:24: 7-bit address
  - bits 23:0: data
- Mode 0 (CPOL=0, CPHA=0): slave shifts MOSI on SCLK rising edge and counts bits on falling edge. Sits between the host/config logic and the modulator's SPI pins.

---
 rtl/spi_master_tx.sv | 200 ++++++++++++++++++++
 tb/tb_spi_master_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// spi_master_tx
//
// SPI mode-0 master that serialises 32-bit register-write frames, MSB first,
// to the coefficient SPI slave. Frame layout: {wr, addr[6:0], data[23:0]}.
//
// Parameters:
//   CLK_DIV  - clk cycles per SCLK half-period (>= 1)
//   HOLD_CYC - clk cycles ss stays low after the 32nd SCLK falling edge (>= 1)
//   GAP_CYC  - minimum clk cycles ss is high between frames (>= 1)
//
// Ports:
//   CLK    in   system clock, all logic on the rising edge
//   reset  in   asynchronous active-high reset
//   start  in   frame request, accepted when busy is low
//   wr     in   R/W bit, sent as frame bit 31
//   addr   in   7-bit register address, frame bits 30:24
//   data   in   24-bit data, frame bits 23:0
//   busy   out  high while a frame (including the trailing gap) is in progress
//   done   out  one-cycle pulse at frame completion
//   SCLK   out  serial clock, idle low
//   MOSI   out  serial data, changes only when SCLK is driven low
//   ss     out  slave select, active low
//
// All outputs come straight from flops; there is no input-to-output path.
// -----------------------------------------------------------------------------
module spi_master_tx #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        wr,
    input  logic [6:0]  addr,
    input  logic [23:0] data,
    output logic        busy,
    output logic        done,
    output logic        SCLK,
    output logic        MOSI,
    output logic        ss
);

    localparam int unsigned CntW = 16;

    // Terminal counts: the phase counter is cleared on entry to each state,
    // so a phase of N cycles ends on the edge where the counter reads N-1.
    localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYC - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StHold,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [31:0]       shreg_q, shreg_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              ss_q, ss_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;

    // State register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        accept    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                accept = start;
            end

            // SCLK low before the first rising edge, MOSI already holds bit 31.
            StSetup: begin
                if (cnt_q == DivLast) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    cnt_d     = '0;
                    state_d   = StHigh;
                end
            end

            StHigh: begin
                if (cnt_q == DivLast) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    if (bit_cnt_q == 6'd32) begin
                        state_d = StHold;
                    end else begin
                        // Next bit goes out on the same edge SCLK falls.
                        shreg_d = {shreg_q[30:0], 1'b0};
                        mosi_d  = shreg_q[30];
                        state_d = StLow;
                    end
                end
            end

            StLow: begin
                if (cnt_q == DivLast) begin
                    sclk_d    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    cnt_d     = '0;
                    state_d   = StHigh;
                end
            end

            // Keep ss low so the slave can decode the frame it just counted.
            StHold: begin
                if (cnt_q == HoldLast) begin
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StGap;
                end
            end

            // A start already pending when the gap expires is taken on that
            // same edge, so back-to-back frames see exactly GAP_CYC of ss high
            // and one frame period between done pulses.
            StGap: begin
                if (cnt_q == GapLast) begin
                    done_d = 1'b1;
                    if (start) begin
                        accept = 1'b1;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            shreg_d   = {wr, addr, data};
            mosi_d    = wr;
            ss_d      = 1'b0;
            sclk_d    = 1'b0;
            busy_d    = 1'b1;
            bit_cnt_d = '0;
            cnt_d     = '0;
            state_d   = StSetup;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign SCLK = sclk_q;
    assign MOSI = mosi_q;
    assign ss   = ss_q;

endmodule

// File: tb/tb_spi_master_tx.sv
`timescale 1ns / 1ps
// Bench for spi_master_tx: a default-parameter instance and a CLK_DIV/HOLD/GAP=1
// instance share the input buses; sel picks which one is driven and monitored.
module tb_spi_master_tx;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic        sel;
    logic        wr;
    logic [6:0]  addr;
    logic [23:0] data;

    logic busy_a, done_a, sclk_a, mosi_a, ss_a;
    logic busy_b, done_b, sclk_b, mosi_b, ss_b;
    logic start_a, start_b;
    logic m_busy, m_done, m_sclk, m_mosi, m_ss;

    always #5 CLK = ~CLK;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_sclk  = sel ? sclk_b : sclk_a;
    assign m_mosi  = sel ? mosi_b : mosi_a;
    assign m_ss    = sel ? ss_b   : ss_a;

    spi_master_tx #(.CLK_DIV(4), .HOLD_CYC(4), .GAP_CYC(4)) u_dut_a (
        .CLK(CLK), .reset(reset), .start(start_a), .wr(wr), .addr(addr), .data(data),
        .busy(busy_a), .done(done_a), .SCLK(sclk_a), .MOSI(mosi_a), .ss(ss_a)
    );

    spi_master_tx #(.CLK_DIV(1), .HOLD_CYC(1), .GAP_CYC(1)) u_dut_b (
        .CLK(CLK), .reset(reset), .start(start_b), .wr(wr), .addr(addr), .data(data),
        .busy(busy_b), .done(done_b), .SCLK(sclk_b), .MOSI(mosi_b), .ss(ss_b)
    );

    typedef struct {
        logic [31:0] word;
        int          ss_low;
        int          lat;
        int          gap;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // gap < 0 means the ss-high time before this frame is not checked.
    task automatic push_exp(input logic [31:0] w, input int d, input int h, input int g,
                            input int gap);
        exp_t e;
        e.word   = w;
        e.ss_low = 64 * d + h;
        e.lat    = 64 * d + h + g;
        e.gap    = gap;
        q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0;
    int          fall_cyc = 0;
    int          end_cyc = 0;
    bit          have_end = 1'b0;
    int          low_cnt = 0;
    int          rises = 0;
    int          falls = 0;
    logic [31:0] cap = '0;
    logic        prev_ss = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_done = 1'b0;

    always @(negedge CLK) begin
        cyc++;
        if (reset) begin
            have_end  = 1'b0;
            prev_ss   = 1'b1;
            prev_sclk = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("done_pulse_width", m_done, 1'b0);
            if (m_done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("frame_word", cap, e.word);
                    check("sclk_rises", rises, 32);
                    check("ss_low_cycles", low_cnt, e.ss_low);
                    check("done_latency", cyc - fall_cyc, e.lat);
                    check("sclk_idle_at_done", m_sclk, 1'b0);
                end
            end
            if (!m_ss && prev_ss) begin
                if (have_end && q.size() != 0 && q[0].gap >= 0)
                    check("ss_high_gap", cyc - end_cyc, q[0].gap);
                fall_cyc = cyc;
                cap      = '0;
                rises    = 0;
                low_cnt  = 0;
                falls++;
            end
            if (m_ss && !prev_ss) begin
                end_cyc  = cyc;
                have_end = 1'b1;
            end
            if (!m_ss) low_cnt++;
            if (m_sclk && !prev_sclk) begin
                cap = {cap[30:0], m_mosi};
                rises++;
            end
            prev_ss   = m_ss;
            prev_sclk = m_sclk;
            prev_done = m_done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic w, input logic [6:0] a, input logic [23:0] d);
        wr    = w;
        addr  = a;
        data  = d;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q.size() != 0 || m_busy) && n < budget) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("idle_timeout", n < budget, 1'b1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ss"}, m_ss, 1'b1);
        check({tag, "_sclk"}, m_sclk, 1'b0);
        check({tag, "_busy"}, m_busy, 1'b0);
        check({tag, "_done"}, m_done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f0;
        int n;
        int r;
        logic ps;

        reset = 1'b1;
        start = 1'b0;
        sel   = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        data  = '0;
        #12;
        check_idle("reset");
        check("reset_mosi", m_mosi, 1'b0);
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // 1: write frame
        push_exp(32'h81ABCDEF, 4, 4, 4, -1);
        issue(1'b1, 7'h01, 24'hABCDEF);
        wait_idle(600);
        check_idle("t1_after");

        // 2: read frame
        push_exp(32'h7F000000, 4, 4, 4, -1);
        issue(1'b0, 7'h7F, 24'h000000);
        wait_idle(600);
        check_idle("t2_after");

        // 3: start while busy is ignored
        f0 = falls;
        push_exp(32'h81ABCDEF, 4, 4, 4, -1);
        issue(1'b1, 7'h01, 24'hABCDEF);
        repeat (99) @(posedge CLK);
        #1;
        addr  = 7'h05;
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        wait_idle(600);
        repeat (5) @(posedge CLK);
        #1;
        check("t3_ss_low_periods", falls - f0, 1);
        check_idle("t3_after");

        // 4: back-to-back with start held high
        push_exp(32'h81000001, 4, 4, 4, -1);
        push_exp(32'h82FFFFFF, 4, 4, 4, 4);
        wr    = 1'b1;
        addr  = 7'h01;
        data  = 24'h000001;
        start = 1'b1;
        @(posedge CLK);
        #1;
        addr = 7'h02;
        data = 24'hFFFFFF;
        n = 0;
        while (!m_done && n < 600) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("t4_first_done_timeout", n < 600, 1'b1);
        start = 1'b0;
        wait_idle(600);
        check_idle("t4_after");

        // 5: reset mid-frame after the 10th SCLK rise
        push_exp(32'h81ABCDEF, 4, 4, 4, -1);
        issue(1'b1, 7'h01, 24'hABCDEF);
        n  = 0;
        r  = 0;
        ps = 1'b0;
        while (r < 10 && n < 500) begin
            @(negedge CLK);
            if (sclk_a && !ps) r++;
            ps = sclk_a;
            n++;
        end
        check("t5_rise_timeout", n < 500, 1'b1);
        #1 reset = 1'b1;
        void'(q.pop_front());
        #1;
        check("t5_async_ss", m_ss, 1'b1);
        check("t5_async_sclk", m_sclk, 1'b0);
        check("t5_async_busy", m_busy, 1'b0);
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
        check("t5_no_done", m_done, 1'b0);
        push_exp(32'h83123456, 4, 4, 4, -1);
        issue(1'b1, 7'h03, 24'h123456);
        wait_idle(600);
        check_idle("t5_after");

        // 6: minimum timing instance
        sel = 1'b1;
        @(posedge CLK);
        #1;
        push_exp(32'h84C0FFEE, 1, 1, 1, -1);
        issue(1'b1, 7'h04, 24'hC0FFEE);
        wait_idle(200);
        check_idle("t6_after");

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
